// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: word size, NOP encoding and fetch FSM states.
package rv_core_pkg;
  localparam int          XLEN       = 32;
  localparam int          ILEN_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} ifetch_state_t;
endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode handshake and redirect input.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst, pc, inst_valid,
    input  imem_ready, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, pc, inst_valid,
    output imem_ready, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch: one outstanding imem request, redirect with stale-response drop.
// Optional IFETCH_PERF_EN adds delivered-instruction and redirect counters.
module ifetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  ifetch_unit_if.master       bus,
`ifdef IFETCH_PERF_EN
  output logic [XLEN-1:0]     perf_fetched,
  output logic [XLEN-1:0]     perf_redirects,
`endif
  output logic                misalign_err
);

  ifetch_state_t   state_q;
  logic            req_q;
  logic            drop_q;
  logic            inst_valid_q;
  logic            misalign_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] next_pc_d;

  logic redir_ok, redir_bad, accept, deliver;

  assign redir_ok  = bus.redirect && (bus.redirect_pc[1:0] == 2'b00);
  assign redir_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  assign accept    = req_q && bus.imem_ready;
  assign deliver   = inst_valid_q && bus.inst_ready;
  assign next_pc_d = pc_q + XLEN'(PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
    end else if (state_q != HALT && redir_bad) begin
      state_q      <= HALT;
      misalign_q   <= 1'b1;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redir_ok) fetch_pc_q <= bus.redirect_pc;
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (redir_ok) fetch_pc_q <= bus.redirect_pc;
          if (accept) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
            drop_q  <= redir_ok;
          end
        end
        WAIT: begin
          // A redirect while a response is outstanding marks it stale; if it lands now, drop it here.
          if (redir_ok) begin
            fetch_pc_q <= bus.redirect_pc;
            if (bus.imem_rvalid) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
              req_q   <= 1'b1;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (bus.imem_rvalid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
              req_q   <= 1'b1;
            end else begin
              inst_q       <= bus.imem_rdata;
              pc_q         <= fetch_pc_q;
              inst_valid_q <= 1'b1;
              state_q      <= HOLD;
            end
          end
        end
        HOLD: begin
          // Redirect wins over sequential advance even if the word is delivered this cycle.
          if (redir_ok || deliver) begin
            inst_valid_q <= 1'b0;
            fetch_pc_q   <= redir_ok ? bus.redirect_pc : next_pc_d;
            state_q      <= REQ;
            req_q        <= 1'b1;
          end
        end
        HALT: ;
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_redirects <= '0;
    end else begin
      if (deliver) perf_fetched <= perf_fetched + 1'b1;
      if (redir_ok && state_q != HALT) perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst       = inst_q;
  assign bus.pc         = pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign misalign_err   = misalign_q;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage for the single-issue RV32I core. It sits directly upstream of the decode/register-file stage.
- Holds the PC and issues one request at a time to an instruction memory with variable latency.
- Presents the fetched word on `inst` with a valid/ready handshake.
- Applies branch redirects from execute and discards stale responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; address of first fetch
PC_STEP, 4, PC increment per delivered instruction (bytes)

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch byte address; stable while imem_req=1 and not accepted
imem_ready  in  1  memory accepts request this cycle (imem_req & imem_ready = accept)
imem_rvalid  in  1  response valid, one cycle per accepted request
imem_rdata  in  32  instruction word
inst  out  32  instruction to decode stage
pc  out  32  address of `inst`
inst_valid  out  1  `inst`/`pc` valid
inst_ready  in  1  decode consumes (inst_valid & inst_ready = deliver)
redirect  in  1  branch/jump taken, one-cycle pulse
redirect_pc  in  32  target address
misalign_err  out  1  sticky: redirect target not 4-byte aligned

Behaviour:
- Reset (async assert): state IDLE, imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0, misalign_err=0, drop=0, fetch_pc=RESET_PC.
- Reset mid-operation: all in-flight state discarded. Any imem_rvalid after deassert with no accepted request is ignored.
- State machine: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: one cycle after reset release -> REQ.
- REQ:
  - imem_req=1, imem_addr=fetch_pc.
  - On accept -> WAIT.
  - imem_req never drops before accept unless a redirect occurs.
- WAIT:
  - imem_req=0.
  - On imem_rvalid (and drop=0): inst<=imem_rdata, pc<=fetch_pc, inst_valid<=1 -> HOLD.
  - On imem_rvalid with drop=1: response discarded, drop<=0 -> REQ.
- HOLD:
  - inst_valid=1; inst/pc held until deliver.
  - On deliver: inst_valid<=0, fetch_pc<=pc+PC_STEP -> REQ (next request starts the following cycle).
- Latency: minimum 3 cycles from request accept to the next request in steady state. One outstanding request maximum.
- imem_rvalid outside WAIT is ignored.
- Redirect, aligned target (redirect_pc[1:0]==0):
  - REQ, not accepted this cycle: fetch_pc<=redirect_pc; stay REQ. imem_addr changes the next cycle.
  - REQ, accepted this same cycle: fetch_pc<=redirect_pc, drop<=1 -> WAIT.
  - WAIT: fetch_pc<=redirect_pc, drop<=1. If imem_rvalid in the same cycle, that response is discarded -> REQ with drop=0.
  - HOLD: inst_valid<=0, held word discarded, fetch_pc<=redirect_pc -> REQ. If deliver is in the same cycle, the word counts as delivered and redirect still wins: next fetch is redirect_pc, not pc+4.
  - IDLE: fetch_pc<=redirect_pc.
- Redirect, misaligned target: misalign_err<=1, inst_valid<=0 -> HALT.
- HALT: no requests, ignores all inputs until rst.
- Arithmetic: PC adds wrap modulo 2^32; 32'hFFFF_FFFC+4 = 0.

Optional Feature:
IFETCH_PERF_EN
- Defined: adds outputs perf_fetched (32) and perf_redirects (32), both reset to 0 and wrapping.
  - perf_fetched increments on each deliver.
  - perf_redirects increments on each accepted aligned redirect.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package rv_core_pkg holds:
  - XLEN=32, NOP_INST=32'h0000_0013, ILEN_BYTES=4
  - typedef enum ifetch_state_t {IDLE, REQ, WAIT, HOLD, HALT}
- Single module; no sub-module needed. The perf counters stay inline under the macro.

Test Plan:
1. Reset release, imem_ready=1, rvalid 1 cycle after accept, inst_ready=1 -> requests at 0x0, 0x4, 0x8; pc/inst match rdata; inst_valid never asserted with stale data.
2. Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst/pc stable, no imem_req; on inst_ready=1, next request to pc+4.
3. imem_ready=0 for 3 cycles -> imem_req=1 and imem_addr stable throughout; accept on cycle 4.
4. redirect to 0x100 during WAIT at fetch_pc 0x8 -> rdata for 0x8 discarded (inst_valid stays 0); next request 0x100; pc=0x100 delivered.
5. redirect to 0x200 coinciding with deliver in HOLD -> next imem_addr 0x200, not pc+4; with IFETCH_PERF_EN, perf_redirects +1.
6. redirect_pc=0x102 -> misalign_err=1, HALT, no imem_req for 20 cycles; async rst pulse mid-cycle -> outputs return to reset values immediately, fetch restarts at RESET_PC.
